// File: rtl/buf_lane_sequencer_if.sv
// rtl/buf_lane_sequencer_if.sv - stream and buffer bus bundle for buf_lane_sequencer
interface buf_lane_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] exp_word;
  logic [31:0] exp_addr;
  logic        exp_en;
  logic        exp_mode;
  logic        core_start;
  logic        core_done;
  logic [31:0] con_word;
  logic [31:0] con_addr;
  logic        con_en;
  logic        con_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Sequencer side
  modport master (
    input  in_valid, in_data, core_done, con_word, out_ready,
    output in_ready, exp_word, exp_addr, exp_en, exp_mode, core_start,
           con_addr, con_en, con_mode, out_valid, out_data
  );

  // Datapath / stream environment side
  modport slave (
    output in_valid, in_data, core_done, con_word, out_ready,
    input  in_ready, exp_word, exp_addr, exp_en, exp_mode, core_start,
           con_addr, con_en, con_mode, out_valid, out_data
  );
endinterface

// File: rtl/buf_lane_sequencer.sv
// rtl/buf_lane_sequencer.sv - frame controller for expand-buffer / core / contract-buffer datapath
module buf_lane_sequencer #(
  parameter int LANES     = 8,
  parameter int IN_WORDS  = LANES,
  parameter int OUT_WORDS = LANES,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  buf_lane_sequencer_if.master bus,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [2:0] {FILL, START, WAIT, CAPTURE, DRAIN} state_t;

  // Frame lengths are clamped to the lane count so an index never leaves the buffer
  localparam int          IN_LAST_I  = ((IN_WORDS  < LANES) ? IN_WORDS  : LANES) - 1;
  localparam int          OUT_LAST_I = ((OUT_WORDS < LANES) ? OUT_WORDS : LANES) - 1;
  localparam logic [2:0]  IN_LAST    = 3'(IN_LAST_I);
  localparam logic [2:0]  OUT_LAST   = 3'(OUT_LAST_I);
  // Expiry fires on the WAIT cycle whose increment would bring wdog to TIMEOUT-1,
  // so err rises TIMEOUT cycles after the core_start cycle
  localparam logic [31:0] WDOG_LAST  = (TIMEOUT > 1) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state_q, state_d;
  logic [2:0]  fill_idx_q, fill_idx_d;
  logic [2:0]  drain_idx_q, drain_idx_d;
  logic [31:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic in_ready_c;
  logic exp_en_c;
  logic exp_mode_c;
  logic core_start_c;
  logic con_en_c;
  logic out_valid_c;

  // State register; asserting reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_idx_q  <= 3'd0;
      drain_idx_q <= 3'd0;
      wdog_q      <= 32'd0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      drain_idx_q <= drain_idx_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state and strobe decode; the input side stays closed while reset is held
  always_comb begin
    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    drain_idx_d  = drain_idx_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;
    in_ready_c   = 1'b0;
    exp_en_c     = 1'b0;
    exp_mode_c   = 1'b0;
    core_start_c = 1'b0;
    con_en_c     = 1'b0;
    out_valid_c  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_c = reset;
        exp_mode_c = reset;
        exp_en_c   = reset & bus.in_valid;
        if (bus.in_valid) begin
          if (fill_idx_q == IN_LAST) begin
            fill_idx_d = 3'd0;
            state_d    = START;
          end else begin
            fill_idx_d = fill_idx_q + 3'd1;
          end
        end
      end
      START: begin
        core_start_c = 1'b1;
        wdog_d       = 32'd0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          state_d = CAPTURE;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 32'd1;
          if (wdog_q + 32'd1 >= WDOG_LAST) begin
            err_d   = 1'b1;
            state_d = FILL;
          end
        end
      end
      CAPTURE: begin
        drain_idx_d = 3'd0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        con_en_c    = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          if (drain_idx_q == OUT_LAST) begin
            drain_idx_d = 3'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = FILL;
          end else begin
            drain_idx_d = drain_idx_q + 3'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.exp_word   = bus.in_data;
  assign bus.exp_addr   = {29'd0, fill_idx_q};
  assign bus.exp_en     = exp_en_c;
  assign bus.exp_mode   = exp_mode_c;
  assign bus.core_start = core_start_c;
  assign bus.con_addr   = {29'd0, drain_idx_q};
  assign bus.con_en     = con_en_c;
  assign bus.con_mode   = 1'b0;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = bus.con_word;

  assign busy      = !((state_q == FILL) && (fill_idx_q == 3'd0));
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_buf_lane_sequencer.sv
// tb/tb_buf_lane_sequencer.sv - self-checking bench for buf_lane_sequencer
module tb_buf_lane_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        busy_a, err_a, busy_b, err_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;

  buf_lane_sequencer_if bus_a ();
  buf_lane_sequencer_if bus_b ();

  buf_lane_sequencer #(.LANES(8), .IN_WORDS(8), .OUT_WORDS(8), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .busy(busy_a), .err(err_a), .frame_cnt(frame_cnt_a)
  );

  buf_lane_sequencer #(.LANES(8), .IN_WORDS(3), .OUT_WORDS(2), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .busy(busy_b), .err(err_b), .frame_cnt(frame_cnt_b)
  );

  logic [31:0] con_lanes_a [8];
  logic [31:0] con_lanes_b [8];
  logic [31:0] exp_mem_a [8];
  logic [31:0] exp_mem_b [8];
  logic [7:0]  exp_wr_mask_b;

  assign bus_a.con_word = con_lanes_a[bus_a.con_addr[2:0]];
  assign bus_b.con_word = con_lanes_b[bus_b.con_addr[2:0]];

  // Expand buffer models: record every written lane
  always @(posedge clk) begin
    if (bus_a.exp_en) exp_mem_a[bus_a.exp_addr[2:0]] <= bus_a.exp_word;
    if (!rst_b) exp_wr_mask_b <= 8'd0;
    else if (bus_b.exp_en) begin
      exp_mem_b[bus_b.exp_addr[2:0]]     <= bus_b.exp_word;
      exp_wr_mask_b[bus_b.exp_addr[2:0]] <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        core_done;
    logic        out_ready;
    logic        x_in_ready;
    logic        x_exp_en;
    logic [31:0] x_exp_addr;
    logic        x_exp_mode;
    logic        x_core_start;
    logic        x_out_valid;
    logic        x_con_en;
    logic [31:0] x_out_data;
    logic        x_busy;
    logic [15:0] x_frame_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [31:0] id, logic cd, logic ordy,
                              logic xr, logic xe, logic [31:0] xa, logic xm, logic xs,
                              logic xov, logic xce, logic [31:0] xd, logic xb, logic [15:0] xf);
    vec_t v;
    v.in_valid = iv; v.in_data = id; v.core_done = cd; v.out_ready = ordy;
    v.x_in_ready = xr; v.x_exp_en = xe; v.x_exp_addr = xa; v.x_exp_mode = xm;
    v.x_core_start = xs; v.x_out_valid = xov; v.x_con_en = xce; v.x_out_data = xd;
    v.x_busy = xb; v.x_frame_cnt = xf;
    return v;
  endfunction

  task automatic set_con_a(input logic [31:0] base);
    for (int i = 0; i < 8; i++) con_lanes_a[i] = base + 32'(i);
  endtask

  // Eight back-to-back words, then the START cycle
  task automatic fill_start_a(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = base + 32'(i);
      #1;
      check("a_fill_exp_en", bus_a.exp_en, 1'b1);
      check("a_fill_exp_addr", bus_a.exp_addr, 32'(i));
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1;
    check("a_core_start", bus_a.core_start, 1'b1);
  endtask

  // Called in the START cycle; core_done arrives 'delay' cycles later, then CAPTURE
  task automatic core_a(input int delay);
    for (int k = 1; k <= delay; k++) begin
      @(negedge clk);
      bus_a.core_done = (k == delay);
      #1;
      check("a_wait_no_out", bus_a.out_valid, 1'b0);
    end
    @(negedge clk);
    bus_a.core_done = 1'b0;
    #1;
    check("a_capture_idle", bus_a.out_valid, 1'b0);
  endtask

  task automatic drain_a(input logic [31:0] base, input bit stall);
    int n;
    bit ended;
    n = 0;
    ended = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      bus_a.out_ready = stall ? (c % 3 == 0) : 1'b1;
      #1;
      if (!bus_a.out_valid) begin
        ended = 1'b1;
        break;
      end
      check("a_drain_in_ready", bus_a.in_ready, 1'b0);
      check("a_drain_con_addr", bus_a.con_addr, 32'(n));
      check("a_drain_data", bus_a.out_data, base + 32'(n));
      if (bus_a.out_ready) n++;
    end
    bus_a.out_ready = 1'b0;
    check("a_drain_end", ended, 1'b1);
    check("a_drain_count", 32'(n), 32'd8);
  endtask

  task automatic frame_b(input logic [31:0] base, input bit gaps);
    int acc;
    int n;
    bit ended;
    acc = 0;
    for (int s = 0; s < 12 && acc < 3; s++) begin
      @(negedge clk);
      bus_b.in_valid = gaps ? (s % 2 == 0) : 1'b1;
      bus_b.in_data  = base + 32'(acc);
      #1;
      if (bus_b.in_valid) begin
        check("b_exp_addr", bus_b.exp_addr, 32'(acc));
        acc++;
      end
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    #1;
    check("b_core_start", bus_b.core_start, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus_b.core_done = (k == 3);
      #1;
    end
    @(negedge clk);
    bus_b.core_done = 1'b0;
    #1;
    check("b_capture_idle", bus_b.out_valid, 1'b0);
    n = 0;
    ended = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (!bus_b.out_valid) begin
        ended = 1'b1;
        break;
      end
      check("b_drain_data", bus_b.out_data, 32'hD0 + 32'(n));
      n++;
    end
    bus_b.out_ready = 1'b0;
    check("b_drain_end", ended, 1'b1);
    check("b_drain_count", 32'(n), 32'd2);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int tcnt;
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 32'd0; bus_a.core_done = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 32'd0; bus_b.core_done = 1'b0; bus_b.out_ready = 1'b0;
    set_con_a(32'hA0);
    for (int i = 0; i < 8; i++) con_lanes_b[i] = 32'hD0 + 32'(i);

    // Cycle table for the first frame: 8 words, core done 5 cycles after start, free drain
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'h10 + 32'(i), 0, 1, 1, 1, 32'(i), 1, 0, 0, 0, 0, (i != 0), 16'd0));
    vecs.push_back(mk(1, 32'hDEAD0000, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'd0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'hDEAD0001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'd0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'd0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'd0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'hA0 + 32'(i), 1, 16'd0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'd1));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", bus_a.in_ready, 1'b0);
    check("rst_exp_mode", bus_a.exp_mode, 1'b0);
    check("rst_core_start", bus_a.core_start, 1'b0);
    check("rst_out_valid", bus_a.out_valid, 1'b0);
    check("rst_con_en", bus_a.con_en, 1'b0);
    check("rst_con_mode", bus_a.con_mode, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
    check("rst_b_frame_cnt", 32'(frame_cnt_b), 32'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus_a.in_valid  = vecs[i].in_valid;
      bus_a.in_data   = vecs[i].in_data;
      bus_a.core_done = vecs[i].core_done;
      bus_a.out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d_in_ready", i), bus_a.in_ready, vecs[i].x_in_ready);
      check($sformatf("vec%0d_exp_en", i), bus_a.exp_en, vecs[i].x_exp_en);
      check($sformatf("vec%0d_exp_addr", i), bus_a.exp_addr, vecs[i].x_exp_addr);
      check($sformatf("vec%0d_exp_mode", i), bus_a.exp_mode, vecs[i].x_exp_mode);
      check($sformatf("vec%0d_core_start", i), bus_a.core_start, vecs[i].x_core_start);
      check($sformatf("vec%0d_out_valid", i), bus_a.out_valid, vecs[i].x_out_valid);
      check($sformatf("vec%0d_con_en", i), bus_a.con_en, vecs[i].x_con_en);
      check($sformatf("vec%0d_con_mode", i), bus_a.con_mode, 1'b0);
      if (vecs[i].x_out_valid)
        check($sformatf("vec%0d_out_data", i), bus_a.out_data, vecs[i].x_out_data);
      check($sformatf("vec%0d_busy", i), busy_a, vecs[i].x_busy);
      check($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt_a), 32'(vecs[i].x_frame_cnt));
    end
    bus_a.in_valid = 1'b0; bus_a.core_done = 1'b0; bus_a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) check("a_exp_mem", exp_mem_a[i], 32'h10 + 32'(i));

    // Backpressure; core_done lands on the watchdog expiry cycle and must win
    set_con_a(32'hB0);
    fill_start_a(32'h20);
    core_a(15);
    check("a_done_wins_err", err_a, 1'b0);
    drain_a(32'hB0, 1'b1);
    check("a_bp_frame_cnt", 32'(frame_cnt_a), 32'd2);
    check("a_bp_err", err_a, 1'b0);

    // Watchdog expiry: err 16 cycles after core_start, frame discarded
    fill_start_a(32'h50);
    tcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (err_a) begin
        tcnt = k;
        break;
      end
    end
    check("a_timeout_cycles", 32'(tcnt), 32'd16);
    check("a_timeout_in_ready", bus_a.in_ready, 1'b1);
    check("a_timeout_busy", busy_a, 1'b0);
    check("a_timeout_frame_cnt", 32'(frame_cnt_a), 32'd2);
    check("a_timeout_no_out", bus_a.out_valid, 1'b0);

    // Next frame completes with err still set
    set_con_a(32'hA0);
    fill_start_a(32'h60);
    core_a(2);
    drain_a(32'hA0, 1'b0);
    check("a_after_to_frame_cnt", 32'(frame_cnt_a), 32'd3);
    check("a_after_to_err", err_a, 1'b1);

    // Reset during DRAIN at drain_idx 3
    fill_start_a(32'h70);
    core_a(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_a.out_ready = 1'b1;
      #1;
      check("a_pre_rst_data", bus_a.out_data, 32'hA0 + 32'(k));
    end
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    #1;
    check("a_pre_rst_con_addr", bus_a.con_addr, 32'd3);
    check("a_pre_rst_valid", bus_a.out_valid, 1'b1);
    rst_a = 1'b0;
    #1;
    check("a_rst_out_valid", bus_a.out_valid, 1'b0);
    check("a_rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
    check("a_rst_err", err_a, 1'b0);
    check("a_rst_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b1;
    fill_start_a(32'h80);
    for (int i = 0; i < 8; i++) check("a_post_rst_exp_mem", exp_mem_a[i], 32'h80 + 32'(i));
    core_a(1);
    drain_a(32'hA0, 1'b0);
    check("a_post_rst_frame_cnt", 32'(frame_cnt_a), 32'd1);

    // Short frames on the second instance, with input gaps
    frame_b(32'h40, 1'b1);
    check("b_wr_mask", 32'(exp_wr_mask_b), 32'h07);
    for (int i = 0; i < 3; i++) check("b_exp_mem", exp_mem_b[i], 32'h40 + 32'(i));
    check("b_frame_cnt1", 32'(frame_cnt_b), 32'd1);
    frame_b(32'h48, 1'b0);
    check("b_frame_cnt2", 32'(frame_cnt_b), 32'd2);
    check("b_wr_mask2", 32'(exp_wr_mask_b), 32'h07);

    // Counter wrap
    @(negedge clk);
    force dut_b.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt_q;
    #1;
    check("b_preset", 32'(frame_cnt_b), 32'hFFFF);
    frame_b(32'h4C, 1'b0);
    check("b_wrap", 32'(frame_cnt_b), 32'd0);
    check("b_err", err_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
